// File: rtl/eb_rd_ptr_ctrl.sv
// ----------------------------------------------------------------------------
// eb_rd_ptr_ctrl
//
// Read-side pointer controller for the PCS RX elastic buffer.
// Brings the gray-coded write pointer across from the recovered-clock domain
// through a two-flop synchroniser, decodes it to binary, owns the binary read
// pointer, and produces empty / fill-level / underflow status for the
// skip/insert logic. The gray-coded read pointer is returned to the write side.
//
// Parameters
//   COUNTER_WIDTH  pointer width including the wrap bit; depth = 2^(CW-1)
//
// Ports
//   clk          in   local read clock, rising edge
//   rst          in   asynchronous active-high reset
//   wr_ptr_gray  in   [CW]   gray write pointer, asynchronous to clk
//   rd_en        in   read request; pops one entry when not empty
//   rd_addr      out  [CW-1] RAM read address (low bits of the read pointer)
//   rd_ptr_gray  out  [CW]   registered gray read pointer for the write side
//   empty        out  registered; synchronised write ptr == read ptr
//   fill_level   out  [CW]   registered entry count, 0 .. 2^(CW-1)
//   underflow    out  registered one-cycle pulse: rd_en while empty
// ----------------------------------------------------------------------------
module eb_rd_ptr_ctrl #(
    parameter int COUNTER_WIDTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [COUNTER_WIDTH-1:0] wr_ptr_gray,
    input  logic                     rd_en,
    output logic [COUNTER_WIDTH-2:0] rd_addr,
    output logic [COUNTER_WIDTH-1:0] rd_ptr_gray,
    output logic                     empty,
    output logic [COUNTER_WIDTH-1:0] fill_level,
    output logic                     underflow
);

    localparam int N = COUNTER_WIDTH;

    logic [N-1:0] wq1;
    logic [N-1:0] wq2;
    logic [N-1:0] wr_bin;
    logic [N-1:0] rd_ptr_bin;
    logic [N-1:0] rd_ptr_next;
    logic [N-1:0] rd_gray_next;
    logic         pop;

    // Two-flop synchroniser. No logic may sit between wq1 and wq2: only a
    // gray-coded bus, which changes one bit at a time, is safe to sample here.
    // NOTE: non-blocking assignments so both flops sample the pre-edge value;
    // blocking would collapse the pair into a single flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wq1 <= '0;
            wq2 <= '0;
        end else begin
            wq1 <= wr_ptr_gray;
            wq2 <= wq1;
        end
    end

    // Gray-to-binary: each binary bit is the XOR of all gray bits at or above it.
    // NOTE: every bit is assigned on every pass, so no latch can be inferred.
    always_comb begin
        wr_bin = '0;
        for (int i = 0; i < N; i++) begin
            wr_bin[i] = ^(wq2 >> i);
        end
    end

    // Pops are gated by the registered empty flag, so an underflowing request
    // leaves the pointer (and the RAM address) untouched.
    assign pop          = rd_en && !empty;
    assign rd_ptr_next  = pop ? rd_ptr_bin + 1'b1 : rd_ptr_bin;
    assign rd_gray_next = rd_ptr_next ^ (rd_ptr_next >> 1);

    // Status is computed from the post-pop pointer so it is already correct in
    // the cycle after a pop, allowing back-to-back reads. Modulo-2^N
    // subtraction lets the wrap bit tell full (2^(N-1)) apart from empty (0).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_bin  <= '0;
            rd_ptr_gray <= '0;
            empty       <= 1'b1;
            fill_level  <= '0;
            underflow   <= 1'b0;
        end else begin
            rd_ptr_bin  <= rd_ptr_next;
            rd_ptr_gray <= rd_gray_next;
            empty       <= (rd_gray_next == wq2);
            fill_level  <= wr_bin - rd_ptr_next;
            underflow   <= rd_en && empty;
        end
    end

    assign rd_addr = rd_ptr_bin[N-2:0];

endmodule

// File: tb/tb_eb_rd_ptr_ctrl.sv
// ----------------------------------------------------------------------------
// tb_eb_rd_ptr_ctrl
//
// Self-checking bench for eb_rd_ptr_ctrl. A behavioural model holds the read
// pointer as an integer count and the synchroniser as a two-deep history of
// decoded write pointers; every clock step compares all outputs against it.
// Directed scenarios add literal expected values on top.
// ----------------------------------------------------------------------------
module tb_eb_rd_ptr_ctrl;

    localparam int N = 4;
    localparam int M = 1 << N;   // pointer modulus
    localparam int D = M / 2;    // buffer depth

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [N-1:0]   wr_ptr_gray = '0;
    logic           rd_en = 1'b0;
    logic [N-2:0]   rd_addr;
    logic [N-1:0]   rd_ptr_gray;
    logic           empty;
    logic [N-1:0]   fill_level;
    logic           underflow;

    int checks = 0;
    int errors = 0;

    // Model state: write-pointer values seen one and two edges ago (binary),
    // read count, and the registered status flags.
    int m_w1, m_w2, m_rd, m_fill;
    bit m_empty, m_uf;

    eb_rd_ptr_ctrl #(.COUNTER_WIDTH(N)) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_ptr_gray (wr_ptr_gray),
        .rd_en       (rd_en),
        .rd_addr     (rd_addr),
        .rd_ptr_gray (rd_ptr_gray),
        .empty       (empty),
        .fill_level  (fill_level),
        .underflow   (underflow)
    );

    always #5 clk = ~clk;

    function automatic int to_gray(int b);
        return (b ^ (b >> 1)) % M;
    endfunction

    function automatic int from_gray(int g);
        int b = 0;
        for (int i = 0; i < N; i++) begin
            int x = 0;
            for (int j = i; j < N; j++) x ^= (g >> j) & 1;
            b |= x << i;
        end
        return b;
    endfunction

    task automatic check(input string tag, input int observed, input int expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic model_reset();
        m_w1 = 0; m_w2 = 0; m_rd = 0; m_fill = 0;
        m_empty = 1'b1; m_uf = 1'b0;
    endtask

    task automatic compare_all(input string tag);
        check({tag, ":rd_addr"},     int'(rd_addr),     m_rd % D);
        check({tag, ":rd_ptr_gray"}, int'(rd_ptr_gray), to_gray(m_rd));
        check({tag, ":empty"},       int'(empty),       int'(m_empty));
        check({tag, ":fill_level"},  int'(fill_level),  m_fill);
        check({tag, ":underflow"},   int'(underflow),   int'(m_uf));
    endtask

    // One clock: apply inputs, advance the model at the edge, compare #1 later.
    task automatic step(input bit ren, input int wr_bin, input string tag);
        int nxt;
        rd_en       = ren;
        wr_ptr_gray = N'(to_gray(wr_bin % M));
        @(posedge clk);
        nxt     = (ren && !m_empty) ? (m_rd + 1) % M : m_rd;
        m_uf    = ren && m_empty;
        m_empty = (nxt == m_w2);
        m_fill  = (m_w2 - nxt + M) % M;
        m_rd    = nxt;
        m_w2    = m_w1;
        m_w1    = from_gray(int'(wr_ptr_gray));
        #1;
        compare_all(tag);
    endtask

    // Asynchronous reset between edges; outputs must clear without a clock.
    task automatic do_reset(input int wr_bin);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        compare_all("reset_async");
        @(posedge clk);
        #3;
        rst = 1'b0;
        wr_ptr_gray = N'(to_gray(wr_bin % M));
    endtask

    int wr_cur;

    initial begin
        model_reset();
        rst = 1'b1;
        #7;
        rst = 1'b0;

        // ---- Burst read: write pointer 4, four pops then one underflow ----
        wr_cur = 4;
        for (int i = 0; i < 3; i++) step(0, wr_cur, "burst_settle");
        check("burst_fill4", int'(fill_level), 4);
        step(1, wr_cur, "burst1");
        check("burst1_addr", int'(rd_addr), 1);
        check("burst1_gray", int'(rd_ptr_gray), 4'b0001);
        check("burst1_fill", int'(fill_level), 3);
        step(1, wr_cur, "burst2");
        check("burst2_gray", int'(rd_ptr_gray), 4'b0011);
        check("burst2_fill", int'(fill_level), 2);
        step(1, wr_cur, "burst3");
        check("burst3_gray", int'(rd_ptr_gray), 4'b0010);
        step(1, wr_cur, "burst4");
        check("burst4_addr", int'(rd_addr), 4);
        check("burst4_gray", int'(rd_ptr_gray), 4'b0110);
        check("burst4_empty", int'(empty), 1);
        step(1, wr_cur, "burst5_uf");
        check("burst5_underflow", int'(underflow), 1);
        check("burst5_addr_hold", int'(rd_addr), 4);
        step(0, wr_cur, "burst_uf_clear");
        check("underflow_one_cycle", int'(underflow), 0);

        // ---- Reset mid-operation (write pointer 0110 driven, pops done) ----
        do_reset(4);
        check("reset_empty", int'(empty), 1);
        check("reset_fill", int'(fill_level), 0);
        wr_cur = 4;
        for (int i = 0; i < 3; i++) step(0, wr_cur, "post_reset_settle");
        check("post_reset_addr", int'(rd_addr), 0);
        step(1, wr_cur, "post_reset_pop");
        check("post_reset_pop_addr", int'(rd_addr), 1);

        // ---- Sync latency: 0 -> 1 visible only two edges later ----
        do_reset(0);
        wr_cur = 0;
        step(0, wr_cur, "lat_idle");
        wr_cur = 1;
        step(0, wr_cur, "lat_k");
        check("lat_k_empty", int'(empty), 1);
        step(0, wr_cur, "lat_k1");
        check("lat_k1_empty", int'(empty), 1);
        check("lat_k1_fill", int'(fill_level), 0);
        step(0, wr_cur, "lat_k2");
        check("lat_k2_empty", int'(empty), 0);
        check("lat_k2_fill", int'(fill_level), 1);

        // ---- Full: write pointer 8 ----
        do_reset(8);
        wr_cur = 8;
        for (int i = 0; i < 3; i++) step(0, wr_cur, "full_settle");
        check("full_fill", int'(fill_level), 8);
        check("full_empty", int'(empty), 0);
        step(1, wr_cur, "full_pop");
        check("full_pop_fill", int'(fill_level), 7);
        check("full_pop_addr", int'(rd_addr), 1);

        // ---- Wrap: bring rd to 14 with write pointer 16 (=0), pop twice ----
        for (int i = 0; i < 7; i++) step(1, wr_cur, "wrap_drain8");
        wr_cur = 14;
        for (int i = 0; i < 3; i++) step(0, wr_cur, "wrap_settle14");
        for (int i = 0; i < 6; i++) step(1, wr_cur, "wrap_drain14");
        check("wrap_pre_addr", int'(rd_addr), 6);
        check("wrap_pre_empty", int'(empty), 1);
        wr_cur = 16;
        for (int i = 0; i < 3; i++) step(0, wr_cur, "wrap_settle0");
        check("wrap_fill2", int'(fill_level), 2);
        step(1, wr_cur, "wrap_pop15");
        check("wrap15_gray", int'(rd_ptr_gray), 4'b1000);
        check("wrap15_addr", int'(rd_addr), 7);
        check("wrap15_fill", int'(fill_level), 1);
        step(1, wr_cur, "wrap_pop0");
        check("wrap0_gray", int'(rd_ptr_gray), 4'b0000);
        check("wrap0_addr", int'(rd_addr), 0);
        check("wrap0_fill", int'(fill_level), 0);
        check("wrap0_empty", int'(empty), 1);

        // ---- Concurrent: fill 2, pop on the edge the new wq2 is used ----
        do_reset(2);
        wr_cur = 2;
        for (int i = 0; i < 3; i++) step(0, wr_cur, "conc_settle");
        check("conc_fill2", int'(fill_level), 2);
        wr_cur = 3;
        step(0, wr_cur, "conc_a");
        step(0, wr_cur, "conc_b");
        step(1, wr_cur, "conc_pop");
        check("conc_fill", int'(fill_level), 2);
        check("conc_empty", int'(empty), 0);

        // ---- Randomised traffic against the model ----
        do_reset(0);
        wr_cur = 0;
        for (int i = 0; i < 400; i++) begin
            // Writer advances by one only while the buffer is not full.
            if ($urandom_range(0, 2) != 0 && (wr_cur - m_rd + 2 * M) % M < D)
                wr_cur = (wr_cur + 1) % M;
            step(1'($urandom_range(0, 1)), wr_cur, "random");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
